// File: rtl/servo_pkg.sv
// Shared constants, types and helpers for the servo scheduler.
// Duty words are counted in clock cycles of the 100 MHz system clock.
package servo_pkg;

    localparam int NUM_SERVOS = 4;
    localparam int SEL_W      = 2;
    localparam int DUTY_W     = 21;

    localparam logic [DUTY_W-1:0] DUTY_MIN    = 21'd100000;
    localparam logic [DUTY_W-1:0] DUTY_MAX    = 21'd200000;
    localparam logic [DUTY_W-1:0] DUTY_CENTER = 21'd150000;
    localparam logic [DUTY_W-1:0] STEP        = 21'd2000;

    // 25 ms of silence from the mux before a channel is skipped
    localparam int TIMEOUT_CYCLES = 2500000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        ADVANCE
    } state_t;

    // Force any requested duty into the mechanically safe window
    function automatic logic [DUTY_W-1:0] clampDuty(input logic [DUTY_W-1:0] duty);
        logic [DUTY_W-1:0] result;
        result = duty;
        if (duty < DUTY_MIN) begin
            result = DUTY_MIN;
        end else if (duty > DUTY_MAX) begin
            result = DUTY_MAX;
        end
        return result;
    endfunction

endpackage

// File: rtl/servo_slew.sv
// Combinational clamp plus one step of slew from the live duty toward a target.
// STEP_SIZE bounds the move; a step as wide as the whole duty window makes the
// output simply the clamped target, which is how the write path reuses it.
import servo_pkg::*;

module servo_slew #(
    parameter logic [DUTY_W-1:0] STEP_SIZE = STEP
) (
    input  logic [DUTY_W-1:0] i_live,
    input  logic [DUTY_W-1:0] i_target,
    output logic [DUTY_W-1:0] o_next
);

    logic [DUTY_W-1:0] w_target;
    logic [DUTY_W-1:0] w_diff;
    logic [DUTY_W-1:0] w_delta;

    // Move toward the clamped target by at most STEP_SIZE; both operands sit in
    // the legal window so neither the add nor the subtract can wrap
    always_comb begin
        w_target = clampDuty(i_target);
        w_diff   = '0;
        w_delta  = '0;
        o_next   = i_live;
        if (w_target > i_live) begin
            w_diff  = w_target - i_live;
            w_delta = (w_diff > STEP_SIZE) ? STEP_SIZE : w_diff;
            o_next  = i_live + w_delta;
        end else if (w_target < i_live) begin
            w_diff  = i_live - w_target;
            w_delta = (w_diff > STEP_SIZE) ? STEP_SIZE : w_diff;
            o_next  = i_live - w_delta;
        end
    end

endmodule

// File: rtl/servo_scheduler.sv
// Round-robin scheduler for the 4-channel servo PWM mux. Each slot loads the
// selected servo's slewed duty, waits for the mux to finish one PWM period
// (or for the watchdog to give up), then moves on to the next servo.
import servo_pkg::*;

module servo_scheduler #(
    parameter int TIMEOUT = TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Enable,
    input  logic                WrEn,
    input  logic [SEL_W-1:0]    WrAddr,
    input  logic [DUTY_W-1:0]   WrDuty,
    input  logic                ActivePeriodFinished,
    output logic [SEL_W-1:0]    ServoNum,
    output logic [DUTY_W-1:0]   ActiveServoDuty,
    output logic [NUM_SERVOS-1:0] AtTarget,
    output logic [NUM_SERVOS-1:0] Fault,
    output logic                Busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t r_state;
    state_t w_nextState;

    logic w_doLoad;
    logic w_doAdvance;
    logic w_setFault;

    logic [DUTY_W-1:0]     r_target [NUM_SERVOS];
    logic [DUTY_W-1:0]     r_live   [NUM_SERVOS];
    logic [SEL_W-1:0]      r_servoNum;
    logic [DUTY_W-1:0]     r_activeDuty;
    logic [NUM_SERVOS-1:0] r_atTarget;
    logic [NUM_SERVOS-1:0] r_fault;
    logic [WD_W-1:0]       r_watchdog;

    logic [DUTY_W-1:0] w_slewNext;
    logic [DUTY_W-1:0] w_wrClamped;

    // One slew step for the servo currently selected; LOAD sees the target as
    // it stood before any write landing in the same cycle
    servo_slew #(
        .STEP_SIZE (STEP)
    ) u_slew (
        .i_live   (r_live[r_servoNum]),
        .i_target (r_target[r_servoNum]),
        .o_next   (w_slewNext)
    );

    // Unbounded step from center yields exactly the clamped write value
    servo_slew #(
        .STEP_SIZE (DUTY_MAX - DUTY_MIN)
    ) u_wrClamp (
        .i_live   (DUTY_CENTER),
        .i_target (WrDuty),
        .o_next   (w_wrClamped)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and per-state control strobes; a pulse beats a
    // simultaneous watchdog expiry, and Enable is only consulted at slot edges
    always_comb begin
        w_nextState = r_state;
        w_doLoad    = 1'b0;
        w_doAdvance = 1'b0;
        w_setFault  = 1'b0;
        case (r_state)
            IDLE: begin
                if (Enable) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_doLoad    = 1'b1;
                w_nextState = WAIT;
            end
            WAIT: begin
                if (ActivePeriodFinished) begin
                    w_nextState = ADVANCE;
                end else if (r_watchdog == WD_LAST) begin
                    w_setFault  = 1'b1;
                    w_nextState = ADVANCE;
                end
            end
            ADVANCE: begin
                w_doAdvance = 1'b1;
                w_nextState = Enable ? LOAD : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Watchdog counts cycles spent waiting for the selected channel's pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_watchdog <= '0;
        end else if (w_doLoad) begin
            r_watchdog <= '0;
        end else if (r_state == WAIT) begin
            r_watchdog <= r_watchdog + WD_W'(1);
        end
    end

    // Commanded targets, accepted in any state and stored already clamped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                r_target[i] <= DUTY_CENTER;
            end
        end else if (WrEn) begin
            r_target[WrAddr] <= w_wrClamped;
        end
    end

    // Live duty of the selected servo takes one slew step per visit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                r_live[i] <= DUTY_CENTER;
            end
        end else if (w_doLoad) begin
            r_live[r_servoNum] <= w_slewNext;
        end
    end

    // Mux-facing select and duty; both hold their values while parked
    always_ff @(posedge clk) begin
        if (rst) begin
            r_servoNum   <= '0;
            r_activeDuty <= DUTY_CENTER;
        end else begin
            if (w_doAdvance) begin
                r_servoNum <= r_servoNum + SEL_W'(1);
            end
            if (w_doLoad) begin
                r_activeDuty <= w_slewNext;
            end
        end
    end

    // Sticky per-channel timeout flags; a faulted channel is still visited
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= '0;
        end else if (w_setFault) begin
            r_fault[r_servoNum] <= 1'b1;
        end
    end

    // Registered live==target status, trailing any change by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_atTarget <= '1;
        end else begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                r_atTarget[i] <= (r_live[i] == r_target[i]);
            end
        end
    end

    assign ServoNum        = r_servoNum;
    assign ActiveServoDuty = r_activeDuty;
    assign AtTarget        = r_atTarget;
    assign Fault           = r_fault;
    assign Busy            = (r_state != IDLE);

endmodule
